// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the RAM-backed streaming FIFO controller.
// The two-entry output buffer and the level width are derived here so every file agrees.
package ram_fifo_ctrl_pkg;

    localparam int OB_DEPTH = 2;
    localparam int OB_CNT_W = 2;

    // Per-cycle handshake events seen by the pointer/count logic.
    typedef struct packed {
        logic push;
        logic issue;
        logic pop;
    } fifo_ops_t;

    function automatic int ram_depth(input int a_width);
        return 1 << a_width;
    endfunction

    // RAM count needs A_WIDTH+1 bits; adding in-flight and buffered words needs one more.
    function automatic int level_width(input int a_width);
        return a_width + 2;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready word stream used on both the producer and consumer side of the FIFO.
interface ram_fifo_ctrl_if #(
    parameter int D_WIDTH = 16
);
    logic               valid;
    logic               ready;
    logic [D_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ram_fifo_outbuf.sv
// Two-entry output buffer that absorbs words returning from the RAM read port.
// Entry 0 is always the FIFO head; pop shifts entry 1 down, append fills the tail.
module ram_fifo_outbuf
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int D_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flush,
    input  logic                i_append,
    input  logic [D_WIDTH-1:0]  i_append_data,
    input  logic                i_pop,
    output logic [OB_CNT_W-1:0] o_count,
    output logic                o_valid,
    output logic [D_WIDTH-1:0]  o_head
);

    logic [OB_CNT_W-1:0] r_count;
    logic [OB_CNT_W-1:0] w_wr_idx;
    logic                w_pop;
    logic [D_WIDTH-1:0]  w_entry [OB_DEPTH];
    logic [D_WIDTH-1:0]  w_shift [OB_DEPTH];

    assign w_pop    = i_pop & (r_count != '0);
    // Tail slot after this edge's pop, so append and pop can share an edge.
    assign w_wr_idx = r_count - OB_CNT_W'(w_pop);

    genvar gi;
    generate
        for (gi = 0; gi < OB_DEPTH; gi++) begin : g_entry
            logic [D_WIDTH-1:0] r_data;

            assign w_entry[gi] = r_data;

            if (gi < OB_DEPTH - 1) begin : g_mid
                assign w_shift[gi] = w_entry[gi+1];
            end else begin : g_last
                assign w_shift[gi] = r_data;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data <= '0;
                end else if (!i_flush) begin
                    if (i_append && (w_wr_idx == OB_CNT_W'(gi))) begin
                        r_data <= i_append_data;
                    end else if (w_pop) begin
                        r_data <= w_shift[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + OB_CNT_W'(i_append) - OB_CNT_W'(w_pop);
        end
    end

    // The read-issue throttle upstream must never let a word arrive with both slots held.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        i_flush || !(i_append && !w_pop && (r_count == OB_CNT_W'(OB_DEPTH))));

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = w_entry[0];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller in front of a simple dual-port RAM with 1-cycle registered read.
// Owns the RAM pointers and occupancy; the output buffer hides the read latency for 1 word/cycle.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    ram_fifo_ctrl_if.slave     s_in,
    ram_fifo_ctrl_if.master    m_out,
    output logic [A_WIDTH+1:0] level,
    output logic [A_WIDTH-1:0] address_write,
    output logic [D_WIDTH-1:0] data_write,
    output logic               write_enable,
    output logic [A_WIDTH-1:0] address_read,
    input  logic [D_WIDTH-1:0] data_read
);

    localparam int DEPTH = ram_depth(A_WIDTH);
    localparam int CNT_W = A_WIDTH + 1;
    localparam int LVL_W = level_width(A_WIDTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [A_WIDTH-1:0]  r_wr_ptr;
    logic [A_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]    r_ram_count;
    logic                r_rd_pending;

    logic                w_can_accept;
    logic                w_in_ready;
    logic [2:0]          w_occ_after_pop;
    fifo_ops_t           w_ops;
    logic [OB_CNT_W-1:0] w_ob_count;
    logic                w_ob_valid;
    logic [D_WIDTH-1:0]  w_ob_head;

    // Reset only gates the visible ready; the state registers are held by reset anyway.
    assign w_can_accept = (r_ram_count != FULL_COUNT) & ~flush;
    assign w_in_ready   = w_can_accept & ~reset;

    always_comb begin
        w_ops           = '0;
        w_occ_after_pop = '0;
        w_ops.push      = s_in.valid & w_can_accept;
        w_ops.pop       = w_ob_valid & m_out.ready;
        // A read may be issued only if its word will find a free buffer slot on arrival.
        w_occ_after_pop = 3'(w_ob_count) + 3'(r_rd_pending) - 3'(w_ops.pop);
        w_ops.issue     = (r_ram_count != '0) & (w_occ_after_pop < 3'd2) & ~flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_count  <= '0;
            r_rd_pending <= 1'b0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_count  <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            r_wr_ptr     <= r_wr_ptr + A_WIDTH'(w_ops.push);
            r_rd_ptr     <= r_rd_ptr + A_WIDTH'(w_ops.issue);
            r_rd_pending <= w_ops.issue;
            case ({w_ops.push, w_ops.issue})
                2'b10:   r_ram_count <= r_ram_count + 1'b1;
                2'b01:   r_ram_count <= r_ram_count - 1'b1;
                default: r_ram_count <= r_ram_count;
            endcase
        end
    end

    ram_fifo_outbuf #(
        .D_WIDTH (D_WIDTH)
    ) u_outbuf (
        .clk           (clk),
        .rst           (reset),
        .i_flush       (flush),
        .i_append      (r_rd_pending),
        .i_append_data (data_read),
        .i_pop         (w_ops.pop),
        .o_count       (w_ob_count),
        .o_valid       (w_ob_valid),
        .o_head        (w_ob_head)
    );

    assign s_in.ready    = w_in_ready;
    assign write_enable  = s_in.valid & w_in_ready;
    assign address_write = r_wr_ptr;
    assign data_write    = s_in.data;
    assign address_read  = r_rd_ptr;

    assign m_out.valid   = w_ob_valid;
    assign m_out.data    = w_ob_head;

    assign level = LVL_W'(r_ram_count) + LVL_W'(r_rd_pending) + LVL_W'(w_ob_count);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural RAM and a word-queue reference model.
module tb_ram_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int CAP   = DEPTH + 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [AW+1:0] level;
    logic [AW-1:0] address_write;
    logic [AW-1:0] address_read;
    logic [DW-1:0] data_write;
    logic [DW-1:0] data_read;
    logic          write_enable;

    ram_fifo_ctrl_if #(.D_WIDTH(DW)) in_if ();
    ram_fifo_ctrl_if #(.D_WIDTH(DW)) out_if ();

    ram_fifo_ctrl #(
        .D_WIDTH (DW),
        .A_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .s_in          (in_if),
        .m_out         (out_if),
        .level         (level),
        .address_write (address_write),
        .data_write    (data_write),
        .write_enable  (write_enable),
        .address_read  (address_read),
        .data_read     (data_read)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM, registered read, both ports on clk.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (write_enable) mem[address_write] <= data_write;
        data_read <= mem[address_read];
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: the FIFO is an ordered queue of accepted words; level is its size.
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            hold_prev = 1'b0;
            chk("rst_level", 32'(level), 32'd0);
        end else begin
            chk("level", 32'(level), 32'(exp_q.size()));
            if (hold_prev) begin
                chk("hold_valid", 32'(out_if.valid), 32'd1);
                chk("hold_data", 32'(out_if.data), 32'(hold_data));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_if.valid && out_if.ready) begin
                    chk("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        logic [DW-1:0] e;
                        e = exp_q.pop_front();
                        chk("out_data", 32'(out_if.data), 32'(e));
                    end
                end
                if (in_if.valid && in_if.ready) exp_q.push_back(in_if.data);
            end
            hold_prev = out_if.valid && !out_if.ready && !flush;
            hold_data = out_if.data;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        flush        = 1'b0;
        @(negedge clk);
        while (level != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_drained"}, 32'(level), 32'd0);
        next_cycle();
        out_if.ready = 1'b0;
    endtask

    task automatic fill(input string tag);
        int acc;
        acc = 0;
        in_if.valid  = 1'b1;
        out_if.ready = 1'b0;
        for (int c = 0; c < 60; c++) begin
            in_if.data = DW'($urandom);
            @(negedge clk);
            if (in_if.valid && in_if.ready) acc++;
            next_cycle();
        end
        in_if.valid = 1'b0;
        chk({tag, "_accepted"}, 32'(acc), 32'(CAP));
        @(negedge clk);
        chk({tag, "_level"}, 32'(level), 32'(CAP));
        next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, sent, got, bubbles, stalls, blocked;
        logic seen;

        in_if.valid  = 1'b1;
        in_if.data   = 16'h1234;
        out_if.ready = 1'b0;
        flush        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_if.valid), 32'd0);
        chk("rst_out_data", 32'(out_if.data), 32'd0);
        chk("rst_level_direct", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(in_if.ready), 32'd0);
        chk("rst_write_enable", 32'(write_enable), 32'd0);
        in_if.valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_if.ready), 32'd1);
        next_cycle();

        // Flow-through latency and ordering on an empty FIFO.
        first = -1;
        out_if.ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_if.valid = (c < 3);
            in_if.data  = DW'(c + 1);
            @(negedge clk);
            if (out_if.valid && first < 0) first = c;
            next_cycle();
        end
        chk("t1_latency", 32'(first), 32'd3);
        chk("t1_level", 32'(level), 32'd0);
        out_if.ready = 1'b0;

        // Capacity is DEPTH + 2, then drain in order.
        fill("t2");
        drain("t2");

        // Full FIFO with simultaneous pop and push.
        fill("t3");
        blocked = 0;
        in_if.valid  = 1'b1;
        out_if.ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_if.data = DW'($urandom);
            @(negedge clk);
            if (c == 0) chk("t3_blocked_first", 32'(in_if.ready), 32'd0);
            else if (!in_if.ready) blocked++;
            next_cycle();
        end
        chk("t3_blocked_later", 32'(blocked), 32'd0);
        drain("t3");

        // Flush with level 10 and a read in flight, plus a concurrent push.
        in_if.valid  = 1'b1;
        out_if.ready = 1'b0;
        for (int c = 0; c < 11; c++) begin
            in_if.data = DW'($urandom);
            next_cycle();
        end
        in_if.valid = 1'b0;
        repeat (3) next_cycle();
        out_if.ready = 1'b1;
        next_cycle();
        out_if.ready = 1'b0;
        flush        = 1'b1;
        in_if.valid  = 1'b1;
        in_if.data   = 16'h5A5A;
        @(negedge clk);
        chk("t4_pre_level", 32'(level), 32'd10);
        next_cycle();
        flush       = 1'b0;
        in_if.valid = 1'b0;
        @(negedge clk);
        chk("t4_post_level", 32'(level), 32'd0);
        chk("t4_post_valid", 32'(out_if.valid), 32'd0);
        next_cycle();
        in_if.valid  = 1'b1;
        in_if.data   = 16'hBEEF;
        out_if.ready = 1'b1;
        next_cycle();
        in_if.valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_if.valid) break;
            next_cycle();
        end
        chk("t4_valid_seen", 32'(out_if.valid), 32'd1);
        chk("t4_first_word", 32'(out_if.data), 32'hBEEF);
        next_cycle();
        drain("t4");

        // Continuous streaming of 200 incrementing words.
        sent = 0; got = 0; bubbles = 0; stalls = 0; seen = 1'b0;
        out_if.ready = 1'b1;
        for (int c = 0; c < 400 && got < 200; c++) begin
            in_if.valid = (sent < 200);
            in_if.data  = DW'(sent);
            @(negedge clk);
            if (in_if.valid && !in_if.ready) stalls++;
            if (in_if.valid && in_if.ready) sent++;
            if (!out_if.valid && seen && got < 200) bubbles++;
            if (out_if.valid) begin
                seen = 1'b1;
                got++;
            end
            next_cycle();
        end
        in_if.valid = 1'b0;
        chk("t5_words_out", 32'(got), 32'd200);
        chk("t5_bubbles", 32'(bubbles), 32'd0);
        chk("t5_input_stalls", 32'(stalls), 32'd0);
        drain("t5");

        // Asynchronous reset in the middle of traffic.
        for (int c = 0; c < 20; c++) begin
            in_if.valid  = 1'b1;
            in_if.data   = DW'($urandom);
            out_if.ready = ($urandom_range(0, 3) == 0);
            next_cycle();
        end
        in_if.valid = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("t6_out_valid", 32'(out_if.valid), 32'd0);
        chk("t6_out_data", 32'(out_if.data), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_in_ready", 32'(in_if.ready), 32'd0);
        chk("t6_write_enable", 32'(write_enable), 32'd0);
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        #1;
        chk("t6_release_ready", 32'(in_if.ready), 32'd1);
        next_cycle();
        out_if.ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_if.valid = 1'b1;
            in_if.data  = DW'($urandom);
            next_cycle();
        end
        drain("t6");

        // Randomised traffic with occasional flush.
        for (int c = 0; c < 2000; c++) begin
            in_if.valid  = ($urandom_range(0, 9) < 6);
            in_if.data   = DW'($urandom);
            out_if.ready = ($urandom_range(0, 1) == 1);
            flush        = ($urandom_range(0, 99) == 0);
            next_cycle();
        end
        drain("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
